// File: rtl/calc_sequencer.sv
// Calculator control sequencer: collects operands, launches the ALU, waits for its
// result and holds the display phase. Adds abort, per-phase timeout, a display hold
// timer and an error state with cause code.
// Optional feature macro: CALC_CHAIN_EN (adds chain/chained for result chaining).
module calc_sequencer #(
  parameter int unsigned NUM_OPERANDS   = 2,
  parameter int unsigned IDX_W          = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TO_W           = 20,
  parameter int unsigned DISP_HOLD      = 50000000,
  parameter int unsigned DH_W           = 26
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             run,
  input  logic             abort,
  input  logic             clr,
  input  logic             opnd_valid,
  output logic             opnd_ready,
  output logic [IDX_W-1:0] opnd_idx,
  output logic             calc_start,
  input  logic             calc_done,
  input  logic             calc_err,
  output logic             disp_en,
  input  logic             disp_ack,
  output logic [2:0]       state,
  output logic             busy,
  output logic             error,
`ifdef CALC_CHAIN_EN
  input  logic             chain,
  output logic             chained,
`endif
  output logic [1:0]       err_code
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StOperand = 3'd1,
    StCalc    = 3'd2,
    StWait    = 3'd3,
    StDisplay = 3'd4,
    StError   = 3'd5
  } state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_OPERANDS - 1);
  localparam logic [TO_W-1:0]  ToLast  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DH_W-1:0]  DhLast  = DH_W'(DISP_HOLD - 1);
  localparam bit               ToEn    = (TIMEOUT_CYCLES != 0);
  localparam bit               DhEn    = (DISP_HOLD != 0);

  localparam logic [1:0] ErrNone   = 2'b00;
  localparam logic [1:0] ErrOpndTo = 2'b01;
  localparam logic [1:0] ErrCalcTo = 2'b10;
  localparam logic [1:0] ErrAlu    = 2'b11;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       err_q, err_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [DH_W-1:0]  dh_q, dh_d;
  logic             chain_sel;
`ifdef CALC_CHAIN_EN
  logic             chained_q, chained_d;
  assign chain_sel = chain;
`else
  assign chain_sel = 1'b0;
`endif

  // Next-state logic; abort outranks progress, progress outranks timeout.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    to_d    = to_q;
    dh_d    = dh_q;
`ifdef CALC_CHAIN_EN
    chained_d = chained_q;
`endif
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run && !abort) begin
            state_d = StOperand;
            idx_d   = '0;
            to_d    = '0;
          end
        end
        StOperand: begin
          // opnd_ready is registered high for the whole OPERAND phase.
          if (opnd_valid) begin
            to_d = '0;
            if (idx_q == LastIdx) state_d = StCalc;
            else                  idx_d   = idx_q + 1'b1;
          end else if (ToEn && (to_q == ToLast)) begin
            state_d = StError;
            err_d   = ErrOpndTo;
          end else begin
            to_d = (to_q == '1) ? to_q : to_q + 1'b1;
          end
        end
        StCalc: begin
          state_d = StWait;
          to_d    = '0;
        end
        StWait: begin
          if (calc_done && calc_err) begin
            state_d = StError;
            err_d   = ErrAlu;
          end else if (calc_done) begin
            state_d = StDisplay;
            dh_d    = '0;
          end else if (ToEn && (to_q == ToLast)) begin
            state_d = StError;
            err_d   = ErrCalcTo;
          end else begin
            to_d = (to_q == '1) ? to_q : to_q + 1'b1;
          end
        end
        StDisplay: begin
          if (disp_ack || (DhEn && (dh_q == DhLast))) begin
            if (chain_sel) begin
              // Operand 0 is the previous result, so collection resumes at index 1.
              state_d = StOperand;
              idx_d   = IDX_W'(1);
              to_d    = '0;
`ifdef CALC_CHAIN_EN
              chained_d = 1'b1;
`endif
            end else begin
              state_d = StIdle;
            end
          end else begin
            dh_d = (dh_q == '1) ? dh_q : dh_q + 1'b1;
          end
        end
        StError: begin
          if (clr) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    // Every entry into IDLE returns the sequencer to its reset-equivalent context.
    if (state_d == StIdle) begin
      idx_d = '0;
      err_d = ErrNone;
      to_d  = '0;
      dh_d  = '0;
    end
`ifdef CALC_CHAIN_EN
    if ((state_d == StIdle) || (state_d == StError)) chained_d = 1'b0;
`endif
  end

  // State, counters and Moore outputs registered from the next state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      err_q      <= ErrNone;
      to_q       <= '0;
      dh_q       <= '0;
      opnd_ready <= 1'b0;
      calc_start <= 1'b0;
      disp_en    <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      to_q       <= to_d;
      dh_q       <= dh_d;
      opnd_ready <= (state_d == StOperand);
      calc_start <= (state_d == StCalc);
      disp_en    <= (state_d == StDisplay);
      busy       <= (state_d != StIdle);
      error      <= (state_d == StError);
    end
  end

`ifdef CALC_CHAIN_EN
  // Chained flag tells the datapath to source operand 0 from the last result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) chained_q <= 1'b0;
    else        chained_q <= chained_d;
  end
  assign chained = chained_q;
`endif

  assign state    = state_q;
  assign opnd_idx = idx_q;
  assign err_code = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: vector table for the main flow plus hand-written
// sequences for timeouts, display hold, async reset and (optionally) chaining.
module tb_calc_sequencer;

  localparam int unsigned N  = 3;
  localparam int unsigned IW = 2;
  localparam int unsigned TO = 8;
  localparam int unsigned TW = 4;
  localparam int unsigned DH = 4;
  localparam int unsigned DW = 3;

  localparam logic [6:0] Z = 7'b0000000;
  localparam logic [6:0] R = 7'b1000000;
  localparam logic [6:0] A = 7'b0100000;
  localparam logic [6:0] C = 7'b0010000;
  localparam logic [6:0] V = 7'b0001000;
  localparam logic [6:0] D = 7'b0000100;
  localparam logic [6:0] E = 7'b0000010;
  localparam logic [6:0] K = 7'b0000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 0, abort = 0, clr = 0, opnd_valid = 0, calc_done = 0, calc_err = 0;
  logic disp_ack = 0;

  logic          ready, start, disp, busy, error;
  logic [IW-1:0] idx;
  logic [2:0]    state;
  logic [1:0]    code;
  logic          ready0, start0, disp0, busy0, error0;
  logic [IW-1:0] idx0;
  logic [2:0]    state0;
  logic [1:0]    code0;
`ifdef CALC_CHAIN_EN
  logic chain = 1'b0;
  logic chained, chained0;
`endif

  logic [11:0] act, act0;
  assign act  = {state, idx, ready, start, disp, busy, error, code};
  assign act0 = {state0, idx0, ready0, start0, disp0, busy0, error0, code0};

  calc_sequencer #(
    .NUM_OPERANDS(N), .IDX_W(IW), .TIMEOUT_CYCLES(TO), .TO_W(TW), .DISP_HOLD(DH), .DH_W(DW)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .run(run), .abort(abort), .clr(clr),
    .opnd_valid(opnd_valid), .opnd_ready(ready), .opnd_idx(idx), .calc_start(start),
    .calc_done(calc_done), .calc_err(calc_err), .disp_en(disp), .disp_ack(disp_ack),
    .state(state), .busy(busy), .error(error),
`ifdef CALC_CHAIN_EN
    .chain(chain), .chained(chained),
`endif
    .err_code(code)
  );

  calc_sequencer #(
    .NUM_OPERANDS(N), .IDX_W(IW), .TIMEOUT_CYCLES(TO), .TO_W(TW), .DISP_HOLD(0), .DH_W(DW)
  ) dut0 (
    .CLK(clk), .RST_N(rst_n), .run(run), .abort(abort), .clr(clr),
    .opnd_valid(opnd_valid), .opnd_ready(ready0), .opnd_idx(idx0), .calc_start(start0),
    .calc_done(calc_done), .calc_err(calc_err), .disp_en(disp0), .disp_ack(disp_ack),
    .state(state0), .busy(busy0), .error(error0),
`ifdef CALC_CHAIN_EN
    .chain(chain), .chained(chained0),
`endif
    .err_code(code0)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [6:0] in;
    logic [2:0] st;
    logic [1:0] ix;
    logic [1:0] cd;
    string      name;
  } vec_t;

  vec_t vecs[$];

  // Expected output tuple: flags follow from the state by their definitions.
  function automatic logic [11:0] expv(input logic [2:0] s, input logic [1:0] i,
                                       input logic [1:0] c);
    return {s, i, s == 3'd1, s == 3'd2, s == 3'd4, s != 3'd0, s == 3'd5, c};
  endfunction

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got st/idx/rdy/start/disp/busy/err/code=%b want %b", name, got, want);
    end
  endtask

  task automatic drive(input logic [6:0] in);
    {run, abort, clr, opnd_valid, calc_done, calc_err, disp_ack} = in;
  endtask

  task automatic step(input logic [6:0] in);
    drive(in);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(Z);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Run one calculation up to entry into WAIT.
  task automatic to_wait();
    step(R);
    step(V);
    step(V);
    step(V);
    step(Z);
  endtask

  initial begin
    vecs.push_back('{R,     3'd1, 2'd0, 2'd0, "run"});
    vecs.push_back('{V,     3'd1, 2'd1, 2'd0, "op0"});
    vecs.push_back('{V,     3'd1, 2'd2, 2'd0, "op1"});
    vecs.push_back('{V,     3'd2, 2'd2, 2'd0, "op2_calc"});
    vecs.push_back('{Z,     3'd3, 2'd2, 2'd0, "wait"});
    vecs.push_back('{D,     3'd4, 2'd2, 2'd0, "done"});
    vecs.push_back('{Z,     3'd4, 2'd2, 2'd0, "hold1"});
    vecs.push_back('{Z,     3'd4, 2'd2, 2'd0, "hold2"});
    vecs.push_back('{Z,     3'd4, 2'd2, 2'd0, "hold3"});
    vecs.push_back('{Z,     3'd0, 2'd0, 2'd0, "hold_expire"});
    vecs.push_back('{R | A, 3'd0, 2'd0, 2'd0, "abort_idle_blocks_run"});
    vecs.push_back('{R,     3'd1, 2'd0, 2'd0, "run2"});
    vecs.push_back('{V,     3'd1, 2'd1, 2'd0, "op0_b"});
    vecs.push_back('{A,     3'd0, 2'd0, 2'd0, "abort_operand"});
    vecs.push_back('{R,     3'd1, 2'd0, 2'd0, "run3"});
    vecs.push_back('{V,     3'd1, 2'd1, 2'd0, "op0_c"});
    vecs.push_back('{V,     3'd1, 2'd2, 2'd0, "op1_c"});
    vecs.push_back('{V,     3'd2, 2'd2, 2'd0, "calc_c"});
    vecs.push_back('{Z,     3'd3, 2'd2, 2'd0, "wait_c"});
    vecs.push_back('{D,     3'd4, 2'd2, 2'd0, "done_c"});
    vecs.push_back('{A,     3'd0, 2'd0, 2'd0, "abort_display"});
    vecs.push_back('{R,     3'd1, 2'd0, 2'd0, "run4"});
    vecs.push_back('{V,     3'd1, 2'd1, 2'd0, "op0_d"});
    vecs.push_back('{V,     3'd1, 2'd2, 2'd0, "op1_d"});
    vecs.push_back('{V,     3'd2, 2'd2, 2'd0, "calc_d"});
    vecs.push_back('{Z,     3'd3, 2'd2, 2'd0, "wait_d"});
    vecs.push_back('{D | E, 3'd5, 2'd2, 2'd3, "alu_err"});
    vecs.push_back('{R,     3'd5, 2'd2, 2'd3, "error_ignores_run"});
    vecs.push_back('{C,     3'd0, 2'd0, 2'd0, "clr"});
    vecs.push_back('{R,     3'd1, 2'd0, 2'd0, "run5"});
    vecs.push_back('{V,     3'd1, 2'd1, 2'd0, "op0_e"});
    vecs.push_back('{V,     3'd1, 2'd2, 2'd0, "op1_e"});
    vecs.push_back('{V,     3'd2, 2'd2, 2'd0, "calc_e"});
    vecs.push_back('{Z,     3'd3, 2'd2, 2'd0, "wait_e"});
    vecs.push_back('{D | E, 3'd5, 2'd2, 2'd3, "alu_err_e"});
    vecs.push_back('{A,     3'd0, 2'd0, 2'd0, "abort_error"});

    do_reset();
    chk("reset", act, expv(3'd0, 2'd0, 2'd0));
    chk("reset_hold0", act0, expv(3'd0, 2'd0, 2'd0));

    foreach (vecs[i]) begin
      step(vecs[i].in);
      chk(vecs[i].name, act, expv(vecs[i].st, vecs[i].ix, vecs[i].cd));
    end

    // Operand timeout after 8 idle cycles, then clear.
    do_reset();
    step(R);
    for (int i = 1; i <= 7; i++) begin
      step(Z);
      chk("opnd_to_pending", act, expv(3'd1, 2'd0, 2'd0));
    end
    step(Z);
    chk("opnd_timeout", act, expv(3'd5, 2'd0, 2'd1));
    step(C);
    chk("opnd_to_clr", act, expv(3'd0, 2'd0, 2'd0));

    // Accept on the final timeout cycle wins over the timeout.
    step(R);
    for (int i = 1; i <= 7; i++) step(Z);
    step(V);
    chk("accept_beats_timeout", act, expv(3'd1, 2'd1, 2'd0));
    step(A);
    chk("abort_after_accept", act, expv(3'd0, 2'd0, 2'd0));

    // Calc timeout.
    do_reset();
    to_wait();
    chk("wait_entry", act, expv(3'd3, 2'd2, 2'd0));
    for (int i = 1; i <= 7; i++) step(Z);
    chk("wait_pending", act, expv(3'd3, 2'd2, 2'd0));
    step(Z);
    chk("calc_timeout", act, expv(3'd5, 2'd2, 2'd2));

    // calc_done on the final timeout cycle wins.
    do_reset();
    to_wait();
    for (int i = 1; i <= 7; i++) step(Z);
    step(D);
    chk("done_beats_timeout", act, expv(3'd4, 2'd2, 2'd0));

    // Display held indefinitely with DISP_HOLD=0 until acknowledged.
    do_reset();
    to_wait();
    step(D);
    chk("hold0_display", act0, expv(3'd4, 2'd2, 2'd0));
    for (int i = 0; i < 100; i++) begin
      step(Z);
      chk("hold0_stays", act0, expv(3'd4, 2'd2, 2'd0));
    end
    step(K);
    chk("hold0_ack", act0, expv(3'd0, 2'd0, 2'd0));

    // Asynchronous reset mid-WAIT takes effect before the next edge.
    do_reset();
    to_wait();
    chk("pre_async_rst", act, expv(3'd3, 2'd2, 2'd0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", act, expv(3'd0, 2'd0, 2'd0));
    chk("async_rst_hold0", act0, expv(3'd0, 2'd0, 2'd0));
    #1;
    rst_n = 1'b1;
    step(Z);
    chk("post_rst_idle", act, expv(3'd0, 2'd0, 2'd0));

`ifdef CALC_CHAIN_EN
    do_reset();
    chk("chained_reset", {11'd0, chained}, 12'd0);
    to_wait();
    step(D);
    chain = 1'b1;
    step(K);
    chk("chain_resume", act, expv(3'd1, 2'd1, 2'd0));
    chk("chained_set", {11'd0, chained}, 12'd1);
    chain = 1'b0;
    step(V);
    chk("chain_op1", act, expv(3'd1, 2'd2, 2'd0));
    step(V);
    chk("chain_calc", act, expv(3'd2, 2'd2, 2'd0));
    step(A);
    chk("chained_clr_idle", {11'd0, chained}, 12'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
